key_schedule_param: RTL and testbench
=====================================

// Module: key_schedule_param
// PURPOSE
//  Parametrised AES key expansion for 128/192/256-bit keys, per FIPS-197.
//  Computes one 32-bit word per enabled clock and stores all round keys in a register file.
//  The cipher datapath reads any round key by index SelKey, with a registered output.
//  Sits beside the round engine and replaces the fixed 128-bit key schedule.
// PARAMETERS
//  KEY_BITS  128  cipher key length; legal values 128, 192, 256
//  NK        KEY_BITS/32  key words (derived; do not override)
//  NR        NK+6         number of rounds (derived; do not override)
// PORTS
//  Clk     in   1         system clock; all state updates on the rising edge
//  Rst     in   1         asynchronous reset, active-low
//  Start   in   1         single-cycle pulse; latch Key_In and begin expansion
//  Key_In  in   KEY_BITS  cipher key; word 0 is in the MSBs
//  En      in   1         generation enable; low stalls expansion, state is held
//  SelKey  in   4         round-key index 0..NR
//  Key     out  128       selected round key, registered
//  Ry      out  1         high when all round keys are valid
// BEHAVIOUR
//  Reset (Rst=0): FSM=IDLE, word counter=0, Key=0, Ry=0; word storage is not cleared.
//  FSM states
//   - IDLE: Start=1 -> LOAD.
//   - LOAD: one cycle; write w[0..NK-1] from the latched key, clear Ry, rcon=01 -> GEN.
//   - GEN: each cycle with En=1, write w[i] for i=NK..4*NR+3; i++.
//     - En=0 holds i, rcon and all stored words.
//     - Last word written -> DONE.
//   - DONE: Ry=1; Start=1 -> LOAD, which clears Ry the next cycle.
//  Word rule
//   - t = w[i-1].
//   - If i%NK==0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}; then rcon = xtime(rcon), so 1b follows 80.
//   - Else if NK==8 and i%NK==4: t = SubWord(t).
//   - w[i] = w[i-NK] ^ t.
//   - Implement i%NK with a wrapping sub-counter, not a divider.
//  Latency from Start=1 to Ry=1
//   - Equals 2 + (4*NR+4-NK) cycles with En held high.
//   - 128: 42 cycles; 192: 48 cycles; 256: 54 cycles.
//  Read port
//   - Key <= {w[4s],w[4s+1],w[4s+2],w[4s+3]} with s=SelKey, one cycle after SelKey is applied.
//   - This applies only when Ry=1 and SelKey<=NR.
//   - Otherwise Key <= 128'h0.
//  Simultaneous events
//   - Start in LOAD or GEN is ignored.
//   - Start in DONE restarts expansion; old keys are invalid from that edge.
//   - Start and En are independent; LOAD proceeds even when En=0.
//  Reset mid-expansion: abort immediately; Ry=0; a new Start is required.
//  Key_In is sampled only on the Start cycle; later changes have no effect.
// CONFIGURATION
//  KS_SEL_ERR_EN defined
//   - Adds output Err (1 bit, registered, reset 0).
//   - Err=1 in the cycle Key updates when SelKey>NR, or when SelKey is read while Ry=0.
//  KS_SEL_ERR_EN undefined
//   - No Err port.
//   - Out-of-range or not-ready reads silently return 128'h0.
// STRUCTURE
//  aes_ks_defs.vh (shared include)
//   - KEY_BITS legality check.
//   - NK/NR derivation macros.
//   - FSM state encodings IDLE/LOAD/GEN/DONE.
//   - xtime function.
//  Sub-module aes_sbox
//   - Combinational 8-bit forward S-box.
//   - Instantiated 4 times for SubWord; shared with the cipher datapath.
//  Storage is reg [31:0] w [0:4*NR+3].
// TESTING
//  T1 (KEY_BITS=128)
//   - Start with Key_In=2b7e151628aed2a6abf7158809cf4f3c, En=1.
//   - Ry rises 42 cycles after Start.
//   - SelKey=1 -> Key=a0fafe1788542cb123a339392a6c7605.
//   - SelKey=10 -> Key=d014f9a8c9ee2589e13f0cc8b6630ca6.
//  T2 (KEY_BITS=192)
//   - Key_In=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
//   - SelKey=12 -> Key=e98ba06f448c773c8ecc720401002202.
//  T3 (KEY_BITS=256)
//   - Key_In=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
//   - SelKey=14 -> Key=fe4890d1e6188d0b046df344706c631e.
//  T4 (KEY_BITS=128)
//   - Toggle En every 3 cycles during GEN.
//   - Round keys match T1.
//   - Ry latency equals 42 cycles + En-low cycles.
//  T5 (KEY_BITS=128)
//   - Pulse Start mid-GEN: ignored, results match T1.
//   - Assert Rst=0 mid-GEN: Ry=0 and Key=0 at once.
//   - A new Start then gives correct keys.
//  T6 (KEY_BITS=128)
//   - SelKey=11 after Ry -> Key=0 (Err=1 with KS_SEL_ERR_EN).
//   - SelKey=0 before Ry -> Key=0.

Source files
------------

// File: rtl/key_schedule_param_pkg.sv
// Shared definitions for the parametrised AES key schedule: FSM encodings,
// key-size derivation and GF(2^8) helpers used by the schedule and the S-box.
package key_schedule_param_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_GEN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef logic [31:0] word_t;

    function automatic int ks_nk(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int ks_nr(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic bit ks_key_bits_ok(input int key_bits);
        return (key_bits == 128) || (key_bits == 192) || (key_bits == 256);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: multiplicative inverse (x^254) followed by
// the FIPS-197 affine transform. Shared with the cipher datapath.
module aes_sbox
    import key_schedule_param_pkg::*;
(
    input  logic [7:0] sbox_in,
    output logic [7:0] sbox_out
);

    logic [7:0] inv;
    logic [7:0] sq;

    // x^254 = product of x^2, x^4, ... x^128; zero maps to zero naturally
    always_comb begin
        sq  = sbox_in;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        sbox_out = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/key_schedule_param.sv
// AES key expansion for 128/192/256-bit keys, one word per enabled clock, with a
// registered round-key read port. Define KS_SEL_ERR_EN to add the Err output.
module key_schedule_param
    import key_schedule_param_pkg::*;
#(
    parameter int KEY_BITS = 128,
    parameter int NK       = ks_nk(KEY_BITS),
    parameter int NR       = ks_nr(KEY_BITS)
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Start,
    input  logic [KEY_BITS-1:0] Key_In,
    input  logic                En,
    input  logic [3:0]          SelKey,
    output logic [127:0]        Key,
    output logic                Ry
`ifdef KS_SEL_ERR_EN
    ,
    output logic                Err
`endif
);

    localparam int NW = 4 * NR + 4;
    localparam int IW = $clog2(NW);

    if (!ks_key_bits_ok(KEY_BITS) || NK != KEY_BITS / 32 || NR != NK + 6) begin : g_bad_cfg
        $error("key_schedule_param: KEY_BITS must be 128, 192 or 256 and NK/NR left derived");
    end

    logic [1:0]          state_reg;
    logic [IW-1:0]       idx_reg;
    logic [2:0]          sub_reg;
    logic [7:0]          rcon_reg;
    logic [KEY_BITS-1:0] key_lat_reg;
    logic                ry_reg;
    logic [127:0]        key_reg;
    word_t               w [0:NW-1];

    word_t prev_word;
    word_t back_word;
    word_t sub_in;
    word_t sub_out;
    word_t temp_word;
    word_t new_word;
    logic  is_rot;
    logic  is_sub_only;
    logic  last_word;

    assign prev_word   = w[idx_reg - IW'(1)];
    assign back_word   = w[idx_reg - IW'(NK)];
    assign is_rot      = (sub_reg == 3'd0);
    assign is_sub_only = (NK == 8) && (sub_reg == 3'd4);
    assign last_word   = (idx_reg == IW'(NW - 1));
    assign sub_in      = is_rot ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
        aes_sbox u_sbox (
            .sbox_in  (sub_in[8*gi +: 8]),
            .sbox_out (sub_out[8*gi +: 8])
        );
    end

    assign temp_word = is_rot      ? (sub_out ^ {rcon_reg, 24'h000000}) :
                       is_sub_only ? sub_out : prev_word;
    assign new_word  = back_word ^ temp_word;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            sub_reg     <= '0;
            rcon_reg    <= 8'h01;
            key_lat_reg <= '0;
            ry_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (Start) begin
                        key_lat_reg <= Key_In;
                        state_reg   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    ry_reg    <= 1'b0;
                    idx_reg   <= IW'(NK);
                    sub_reg   <= 3'd0;
                    rcon_reg  <= 8'h01;
                    state_reg <= ST_GEN;
                end
                ST_GEN: begin
                    if (En) begin
                        idx_reg <= idx_reg + IW'(1);
                        sub_reg <= (sub_reg == 3'(NK - 1)) ? 3'd0 : sub_reg + 3'd1;
                        if (is_rot) rcon_reg <= xtime(rcon_reg);
                        if (last_word) begin
                            state_reg <= ST_DONE;
                            ry_reg    <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (Start) begin
                        key_lat_reg <= Key_In;
                        state_reg   <= ST_LOAD;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Word storage is deliberately left out of reset
    always_ff @(posedge Clk) begin
        if (state_reg == ST_LOAD) begin
            for (int k = 0; k < NK; k++) begin
                w[k] <= key_lat_reg[KEY_BITS-1-32*k -: 32];
            end
        end else if (state_reg == ST_GEN && En) begin
            w[idx_reg] <= new_word;
        end
    end

    // Keys count as valid only while settled in DONE, so a restart hides them at once
    logic          rd_ok;
    logic [IW-1:0] rd_base;
    logic [127:0]  rd_data;

    assign rd_ok   = ry_reg && (state_reg == ST_DONE) && (SelKey <= 4'(NR));
    assign rd_base = IW'({SelKey, 2'b00});

    for (genvar gi = 0; gi < 4; gi++) begin : g_rd
        assign rd_data[127-32*gi -: 32] = w[rd_base + IW'(gi)];
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            key_reg <= '0;
        end else begin
            key_reg <= rd_ok ? rd_data : 128'h0;
        end
    end

`ifdef KS_SEL_ERR_EN
    logic err_reg;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= !rd_ok;
        end
    end

    assign Err = err_reg;
`endif

    assign Key = key_reg;
    assign Ry  = ry_reg;

endmodule

// File: tb/tb_key_schedule_param.sv
// Scoreboard bench for key_schedule_param with 128/192/256-bit instances side by side.
`timescale 1ns/1ps
module tb_key_schedule_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [2:0]   start;
    logic [2:0]   en;
    logic [3:0]   sel [3];
    logic [127:0] key_in128;
    logic [191:0] key_in192;
    logic [255:0] key_in256;
    logic [127:0] key_out [3];
    logic [2:0]   ry;
`ifdef KS_SEL_ERR_EN
    logic [2:0]   err;
`endif

    key_schedule_param #(.KEY_BITS(128)) u_dut128 (
        .Clk(clk), .Rst(rst_n), .Start(start[0]), .Key_In(key_in128), .En(en[0]),
        .SelKey(sel[0]), .Key(key_out[0]), .Ry(ry[0])
`ifdef KS_SEL_ERR_EN
        , .Err(err[0])
`endif
    );

    key_schedule_param #(.KEY_BITS(192)) u_dut192 (
        .Clk(clk), .Rst(rst_n), .Start(start[1]), .Key_In(key_in192), .En(en[1]),
        .SelKey(sel[1]), .Key(key_out[1]), .Ry(ry[1])
`ifdef KS_SEL_ERR_EN
        , .Err(err[1])
`endif
    );

    key_schedule_param #(.KEY_BITS(256)) u_dut256 (
        .Clk(clk), .Rst(rst_n), .Start(start[2]), .Key_In(key_in256), .En(en[2]),
        .SelKey(sel[2]), .Key(key_out[2]), .Ry(ry[2])
`ifdef KS_SEL_ERR_EN
        , .Err(err[2])
`endif
    );

    localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R128_1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R128_2 = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] R128_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R192_0 = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] R192_1 = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] R192_C = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256_0 = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] R256_1 = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R256_2 = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] R256_E = 128'hfe4890d1e6188d0b046df344706c631e;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int           dut;
        logic [127:0] exp;
        logic         err;
        string        name;
    } rd_t;

    rd_t  sb_q [$];
    logic rd_issue = 1'b0;

    // Monitor: Key reflects SelKey one edge after it is applied
    initial begin
        rd_t e;
        forever begin
            @(posedge clk);
            if (rd_issue) begin
                #1;
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 128'd1, 128'd0);
                end else begin
                    e = sb_q.pop_front();
                    $display("read %s dut%0d key=%h", e.name, e.dut, key_out[e.dut]);
                    check(e.name, key_out[e.dut], e.exp);
`ifdef KS_SEL_ERR_EN
                    check({e.name, "_err"}, 128'(err[e.dut]), 128'(e.err));
`endif
                end
            end
        end
    end

    task automatic do_read(input int d, input logic [3:0] s, input logic [127:0] exp,
                           input logic e, input string name);
        rd_t item;
        @(negedge clk);
        sel[d]    = s;
        item.dut  = d;
        item.exp  = exp;
        item.err  = e;
        item.name = name;
        sb_q.push_back(item);
        rd_issue = 1'b1;
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    // Pulse Start and count edges until Ry rises; optional En toggling and mid-GEN Start
    task automatic run_expand(input int d, input int base_lat, input bit toggle_en,
                              input bit mid_start, input string name);
        int lat;
        int lows;
        bit seen_low;
        bit done;
        logic [127:0] saved;
        saved = key_in128;
        @(negedge clk);
        start[d] = 1'b1;
        en[d]    = 1'b1;
        lat = 0; lows = 0; seen_low = 1'b0; done = 1'b0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                start[d] = 1'b0;
                if (d == 0) key_in128 = 128'hdeadbeef_00000000_cafef00d_12345678;
            end
            if (lat == 2) check({name, "_ry_cleared"}, 128'(ry[d]), 128'd0);
            if (ry[d] == 1'b0) seen_low = 1'b1;
            else if (seen_low) done = 1'b1;
            if (!done) begin
                if (toggle_en && lat >= 2) en[d] = ((lat / 3) % 2 == 1) ? 1'b0 : 1'b1;
                if (lat >= 2 && en[d] == 1'b0) lows++;
                if (mid_start) start[d] = (lat == 10);
            end
        end
        en[d]     = 1'b1;
        start[d]  = 1'b0;
        key_in128 = saved;
        $display("expand %s dut%0d latency=%0d en_low=%0d", name, d, lat, lows);
        check({name, "_latency"}, 128'(lat), 128'(base_lat + lows));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = '0;
        en        = 3'b111;
        sel[0]    = 4'd0;
        sel[1]    = 4'd0;
        sel[2]    = 4'd0;
        key_in128 = K128;
        key_in192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
        key_in256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_ry_dut%0d", d), 128'(ry[d]), 128'd0);
            check($sformatf("reset_key_dut%0d", d), key_out[d], 128'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        do_read(0, 4'd0, 128'h0, 1'b1, "t6_before_ry");

        run_expand(0, 42, 1'b0, 1'b0, "t1");
        do_read(0, 4'd0,  K128,    1'b0, "t1_sel0");
        do_read(0, 4'd1,  R128_1,  1'b0, "t1_sel1");
        do_read(0, 4'd2,  R128_2,  1'b0, "t1_sel2");
        do_read(0, 4'd10, R128_A,  1'b0, "t1_sel10");
        do_read(0, 4'd11, 128'h0,  1'b1, "t6_sel11");
        do_read(0, 4'd15, 128'h0,  1'b1, "t6_sel15");

        run_expand(1, 48, 1'b0, 1'b0, "t2");
        do_read(1, 4'd0,  R192_0,  1'b0, "t2_sel0");
        do_read(1, 4'd1,  R192_1,  1'b0, "t2_sel1");
        do_read(1, 4'd12, R192_C,  1'b0, "t2_sel12");
        do_read(1, 4'd13, 128'h0,  1'b1, "t2_sel13");

        run_expand(2, 54, 1'b0, 1'b0, "t3");
        do_read(2, 4'd0,  R256_0,  1'b0, "t3_sel0");
        do_read(2, 4'd1,  R256_1,  1'b0, "t3_sel1");
        do_read(2, 4'd2,  R256_2,  1'b0, "t3_sel2");
        do_read(2, 4'd14, R256_E,  1'b0, "t3_sel14");
        do_read(2, 4'd15, 128'h0,  1'b1, "t3_sel15");

        run_expand(0, 42, 1'b1, 1'b0, "t4");
        do_read(0, 4'd1,  R128_1,  1'b0, "t4_sel1");
        do_read(0, 4'd10, R128_A,  1'b0, "t4_sel10");

        run_expand(0, 42, 1'b0, 1'b1, "t5a");
        do_read(0, 4'd1,  R128_1,  1'b0, "t5a_sel1");
        do_read(0, 4'd10, R128_A,  1'b0, "t5a_sel10");

        // Reset mid-GEN while the 192-bit instance is driving a live key
        do_read(1, 4'd1, R192_1, 1'b0, "t5_pre_rst_192");
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("t5_rst_ry_dut%0d", d), 128'(ry[d]), 128'd0);
            check($sformatf("t5_rst_key_dut%0d", d), key_out[d], 128'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_read(1, 4'd1, 128'h0, 1'b1, "t5_post_rst_192");

        run_expand(0, 42, 1'b0, 1'b0, "t5b");
        do_read(0, 4'd1,  R128_1,  1'b0, "t5b_sel1");
        do_read(0, 4'd10, R128_A,  1'b0, "t5b_sel10");

        repeat (3) @(negedge clk);
        check("sb_drained", 128'(sb_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
